// File: rtl/dsp_io_bridge_if.sv
// rtl/dsp_io_bridge_if.sv - DSP port-I/O and shared-RAM signal bundle for dsp_io_bridge
//
// Purpose: groups the DSP IN/OUT port signals, the shared-RAM request
// channel and the host/DSP flag signals into one interface.
// Modports:
//   slave  - the bridge itself (consumes DSP strobes and RAM acks)
//   master - the environment (DSP core, host arbiter, shared RAM)
// Signals:
//   port_a[2:0]   DSP port address         port_di[15:0] DSP OUT data
//   portw         DSP OUT strobe           portr         DSP IN strobe
//   port_do[15:0] data returned on IN      dsp_hold      DSP stall
//   mem_a[11:0]   RAM word address         mem_do[15:0]  RAM write data
//   mem_di[15:0]  RAM read data            mem_we        write qualifier
//   mem_req       RAM request              mem_ack       RAM grant/completion
//   host_bio      host-to-DSP flag         dsp_flag      DSP-to-host flag
//   ovr_err       sticky strobe-while-busy / dual-strobe flag

interface dsp_io_bridge_if;
  logic [2:0]  port_a;
  logic [15:0] port_di;
  logic        portw;
  logic        portr;
  logic [15:0] port_do;
  logic        dsp_hold;
  logic [11:0] mem_a;
  logic [15:0] mem_do;
  logic [15:0] mem_di;
  logic        mem_we;
  logic        mem_req;
  logic        mem_ack;
  logic        host_bio;
  logic        dsp_flag;
  logic        ovr_err;

  modport slave (
    input  port_a, port_di, portw, portr, mem_di, mem_ack, host_bio,
    output port_do, dsp_hold, mem_a, mem_do, mem_we, mem_req, dsp_flag, ovr_err
  );

  modport master (
    output port_a, port_di, portw, portr, mem_di, mem_ack, host_bio,
    input  port_do, dsp_hold, mem_a, mem_do, mem_we, mem_req, dsp_flag, ovr_err
  );
endinterface

// File: rtl/dsp_io_bridge.sv
// rtl/dsp_io_bridge.sv - DSP IN/OUT port decoder bridging to a shared RAM and host flags
//
// Purpose: decodes the DSP port map (0 address register, 1 shared-RAM data,
// 2 status, 3 flag control, 4-7 unmapped). Port 1 accesses become a
// request/acknowledge transaction to the host-arbitrated RAM with the DSP
// held stalled until the access completes; the address register then
// post-increments modulo 4096.
// Ports:
//   clk  - system clock, all state updates on its rising edge
//   rst  - synchronous active-high reset
//   bus  - dsp_io_bridge_if.slave (see interface file for signal list)

module dsp_io_bridge (
  input  logic           clk,
  input  logic           rst,
  dsp_io_bridge_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [11:0] addr;
  logic [15:0] port_do_q;
  logic [15:0] mem_do_q;
  logic        dsp_flag_q;
  logic        ovr_err_q;

  logic        busy;
  logic        mem_sel;
  logic        acc_w;
  logic        acc_r;
  logic        strobe;
  logic [15:0] rd_data;

  assign busy    = (state != IDLE);
  assign mem_sel = (bus.port_a == 3'd1);
  assign strobe  = bus.portr | bus.portw;

  // Strobes are only accepted while idle; a simultaneous IN/OUT pair is
  // treated as an OUT only.
  assign acc_w = bus.portw & ~busy;
  assign acc_r = bus.portr & ~bus.portw & ~busy;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (acc_w && mem_sel) begin
          state_nxt = WR;
        end else if (acc_r && mem_sel) begin
          state_nxt = RD;
        end
      end
      RD, WR: begin
        if (bus.mem_ack) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs; hold also covers the strobe cycle itself so the DSP
  // never advances past a port-1 access before the RAM completes it.
  always_comb begin
    bus.mem_req  = 1'b0;
    bus.mem_we   = 1'b0;
    case (state)
      RD: bus.mem_req = 1'b1;
      WR: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = 1'b1;
      end
      default: ;
    endcase
    bus.dsp_hold = (strobe & mem_sel) | busy;
  end

  // Read mux for the non-memory ports
  always_comb begin
    rd_data = 16'h0000;
    case (bus.port_a)
      3'd0:    rd_data = {4'b0000, addr};
      3'd2:    rd_data = {14'b0, bus.host_bio, busy};
      3'd3:    rd_data = {15'b0, dsp_flag_q};
      default: rd_data = 16'h0000;
    endcase
  end

  // Datapath registers. Port accesses only happen in IDLE and acks only
  // count outside IDLE, so the two update groups never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr       <= 12'h000;
      port_do_q  <= 16'h0000;
      mem_do_q   <= 16'h0000;
      dsp_flag_q <= 1'b0;
      ovr_err_q  <= 1'b0;
    end else begin
      if (strobe && (busy || (bus.portr && bus.portw))) begin
        ovr_err_q <= 1'b1;
      end
      if (acc_w) begin
        case (bus.port_a)
          3'd0:    addr       <= bus.port_di[11:0];
          3'd1:    mem_do_q   <= bus.port_di;
          3'd3:    dsp_flag_q <= bus.port_di[0];
          default: ;
        endcase
      end
      if (acc_r && !mem_sel) begin
        port_do_q <= rd_data;
      end
      if (busy && bus.mem_ack) begin
        addr <= addr + 12'd1;
        if (state == RD) begin
          port_do_q <= bus.mem_di;
        end
      end
    end
  end

  assign bus.port_do  = port_do_q;
  assign bus.mem_a    = addr;
  assign bus.mem_do   = mem_do_q;
  assign bus.dsp_flag = dsp_flag_q;
  assign bus.ovr_err  = ovr_err_q;

endmodule

// File: doc/dsp_io_bridge.md
DSP_IO_BRIDGE -- requirements
Module: dsp_io_bridge

Interface
REQ-001 SHALL have one clock CLK; reset RST is synchronous and active-high; all state SHALL update on the rising edge of CLK.
REQ-002 SHALL have port CLK, input, 1, system clock.
REQ-003 SHALL have port RST, input, 1, synchronous active-high reset.
REQ-004 SHALL have port PORT_A, input, 3, DSP port address (IN/OUT PA field).
REQ-005 SHALL have port PORT_DI, input, 16, data driven by the DSP on OUT.
REQ-006 SHALL have port PORTW, input, 1, one-cycle DSP OUT strobe.
REQ-007 SHALL have port PORTR, input, 1, one-cycle DSP IN strobe.
REQ-008 SHALL have port PORT_DO, output, 16, data returned to the DSP for IN.
REQ-009 SHALL have port DSP_HOLD, output, 1, stalls the DSP core state while high.
REQ-010 SHALL have port MEM_A, output, 12, shared-RAM word address.
REQ-011 SHALL have port MEM_DO, output, 16, shared-RAM write data.
REQ-012 SHALL have port MEM_DI, input, 16, shared-RAM read data, valid with MEM_ACK.
REQ-013 SHALL have port MEM_WE, output, 1, write qualifier for MEM_REQ.
REQ-014 SHALL have port MEM_REQ, output, 1, access request, held until acknowledged.
REQ-015 SHALL have port MEM_ACK, input, 1, one-cycle grant/completion from the host arbiter.
REQ-016 SHALL have port HOST_BIO, input, 1, host-to-DSP flag.
REQ-017 SHALL have port DSP_FLAG, output, 1, DSP-to-host flag.
REQ-018 SHALL have port OVR_ERR, output, 1, sticky flag for a strobe received while busy.

Function
REQ-019 SHALL decode the port map as follows: port 0 is the address register ADDR[11:0]; port 1 is shared-RAM data; port 2 is status (read-only); port 3 is flag control; ports 4-7 are unmapped.
REQ-020 SHALL handle a port 0 write by setting ADDR to PORT_DI[11:0] in the next cycle, without asserting HOLD.
REQ-021 SHALL handle a port 0 read by returning {4'b0,ADDR}.
REQ-022 SHALL handle a port 3 write by setting DSP_FLAG to PORT_DI[0] in the next cycle.
REQ-023 SHALL handle a port 3 read by returning {15'b0,DSP_FLAG}.
REQ-024 SHALL handle a port 2 read by returning {14'b0,HOST_BIO,busy}, where busy means the FSM is not in IDLE.
REQ-025 SHALL ignore writes to ports 2 and 4-7; reads of ports 4-7 SHALL return 16'h0000.
REQ-026 SHALL register PORT_DO for non-memory reads: it updates in cycle N+1 after PORTR in cycle N and holds until the next read completes.
REQ-027 SHALL implement an FSM with states IDLE, RD and WR.
REQ-028 SHALL transition IDLE->RD on PORTR with PORT_A=1: from cycle N+1, MEM_REQ=1, MEM_WE=0, MEM_A=ADDR.
REQ-029 SHALL transition IDLE->WR on PORTW with PORT_A=1: MEM_DO latches PORT_DI; from cycle N+1, MEM_REQ=1, MEM_WE=1, MEM_A=ADDR.
REQ-030 SHALL hold MEM_REQ, MEM_A, MEM_DO and MEM_WE stable in RD/WR until MEM_ACK is sampled high.
REQ-031 SHALL, on MEM_ACK in RD at cycle M: in M+1 set PORT_DO=MEM_DI, MEM_REQ=0, ADDR=ADDR+1, state IDLE.
REQ-032 SHALL, on MEM_ACK in WR at cycle M: in M+1 set MEM_REQ=0, ADDR=ADDR+1, state IDLE.
REQ-033 SHALL increment ADDR modulo 4096 (12'hFFF -> 12'h000).
REQ-034 SHALL drive DSP_HOLD combinationally as (PORTR|PORTW)&(PORT_A==1) OR state!=IDLE, so the DSP is stalled from the strobe cycle until the cycle after MEM_ACK.
REQ-035 SHALL ignore any PORTR/PORTW arriving while state!=IDLE (no register change) and SHALL set OVR_ERR.
REQ-036 SHALL ignore MEM_ACK while in IDLE.
REQ-037 SHALL, if PORTR and PORTW are asserted in the same cycle, process PORTW only and set OVR_ERR.

Reset
REQ-038 SHALL, while RST is high, set: state=IDLE, ADDR=0, PORT_DO=0, MEM_REQ=0, MEM_WE=0, MEM_A=0, MEM_DO=0, DSP_FLAG=0, OVR_ERR=0.
REQ-039 SHALL, on RST asserted mid-transaction, drop MEM_REQ in the next cycle and discard any pending MEM_ACK; DSP_HOLD SHALL follow REQ-034 from the reset state.

Verification
REQ-040 SHALL cover: OUT port0 16'h0FFE, then OUT port1 16'hBEEF with ACK 3 cycles later -> MEM_A=12'hFFE, MEM_WE=1, MEM_DO=16'hBEEF, HOLD high 5 cycles, ADDR=12'hFFF after.
REQ-041 SHALL cover: ADDR=12'hFFF, IN port1 with MEM_DI=16'h1234 at ACK -> PORT_DO=16'h1234 in the cycle HOLD falls, ADDR wraps to 12'h000.
REQ-042 SHALL cover: OUT port3 16'h0001, then IN port3 and IN port2 with HOST_BIO=1 while idle -> DSP_FLAG=1, PORT_DO=16'h0001 then 16'h0002, HOLD never asserted.
REQ-043 SHALL cover: PORTW port0 16'h0123 while in RD -> ADDR unchanged, OVR_ERR=1 and remains 1 until RST.
REQ-044 SHALL cover: RST pulsed while in WR with MEM_REQ high -> MEM_REQ=0 next cycle, a late ACK is ignored, all outputs at their reset values.
REQ-045 SHALL cover: IN port5 -> PORT_DO=16'h0000; OUT port6 -> no state change, no MEM_REQ.
